hazard_forward_unit: RTL and testbench
======================================

# hazard_forward_unit

Parametrised data-hazard unit for the pipelined 8-bit MIPS core; it sits between decode and execute. It tracks destination registers of the last DEPTH in-flight instructions and produces a per-source forwarding select from those stages. It adds load-use stall generation, write-enable and valid qualification of matches, and flush handling.

## Interface

Parameters:
- REG_AW, 5, register address width.
- DEPTH, 3, number of tracked older instructions; history stages 1..DEPTH, with 1 the youngest (execute).
- NSRC, 2, source operands per instruction.
- SELW, $clog2(DEPTH+1), select width; derived, not overridable.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- reset  in  1  synchronous, active-low; 0 clears all state on the next posedge.
- ins_valid  in  1  decoded instruction present.
- src_addr  in  NSRC*REG_AW  source register addresses; source i is at [i*REG_AW +: REG_AW].
- src_used  in  NSRC  source i is actually read.
- dst_addr  in  REG_AW  destination register.
- dst_we  in  1  instruction writes dst_addr.
- is_load  in  1  instruction is LD; result is ready only after the memory stage.
- flush  in  1  squash the current decode instruction.
- fwd_sel  out  NSRC*SELW  per source: 0 selects the register file, k selects the result of history stage k.
- stall  out  1  load-use hazard; decode holds the instruction.
- issue  out  1  instruction enters history this cycle.

## Operation

- History is a shift register of DEPTH entries {valid, we, load, addr}.
- Posedge with reset=1: entry[k+1] <= entry[k].
- Entry[1] takes {ins_valid&issue, dst_we, is_load, dst_addr} when issue=1. Otherwise it takes a bubble (valid=0).
- issue = ins_valid & ~stall & ~flush.
- Match on source i at stage k: src_used[i] & entry[k].valid & entry[k].we & (entry[k].addr == src i).
- fwd_sel[i] = smallest matching k (youngest wins), else 0.
- stall = ins_valid & ~flush & some source matches stage 1 with entry[1].load=1.
- While stall=1, fwd_sel is don't-care; the bench checks it only when issue=1.
- After a stall cycle, the load has moved to stage 2, so the same source gets fwd_sel=2 (memory stage).
- Flush: the current instruction is not inserted; older entries continue to shift, since they are committed. Flush overrides stall.
- A source matching only beyond stage DEPTH uses the register file (fwd_sel=0). This is a write-back-before-read design assumption.
- Both sources may match independent or identical stages.
- A destination equal to its own source does not self-match; comparisons are against history only.

## Timing

- fwd_sel, stall and issue are combinational from the current inputs and the registered history. Zero-cycle latency.
- History update latency is 1 cycle: an instruction issued at cycle n is visible as stage 1 at cycle n+1, and as stage k at n+k.
- Load-use costs exactly 1 bubble. Back-to-back dependent loads each cost 1 bubble.
- Reset value: all entries valid=0. Hence fwd_sel=0, stall=0, and issue=ins_valid&~flush.
- Reset asserted mid-operation discards all history at that posedge. No stall persists after reset.

## Configuration

- HFU_ZERO_REG_EN defined: register address 0 is hardwired zero. A source of 0 never matches, so fwd_sel=0 and it never causes a stall. Entries with addr 0 are stored with we=0.
- HFU_ZERO_REG_EN undefined: r0 is an ordinary register and participates in matching.

## Structure

- Package hfu_pkg:
  - typedef hist_entry_t {valid, we, load, addr[REG_AW]}.
  - Constant FWD_RF = 0.
  - Function sel_width(depth).
- Sub-module hfu_match, instantiated NSRC times. It takes one source plus the history, and returns a SELW-wide priority-encoded select and a load_hit flag for stage 1.
- Top level holds the history shift register, the stall/issue logic and the flush gating.

## Test plan

- Defaults. Issue ADD r3←… then SUB using src r3 on the next cycle → fwd_sel[0]=1, stall=0. Insert one unrelated instruction between them → fwd_sel=2. Insert two → 3. Insert three → 0.
- LD r4 then ADD using r4 in the next cycle → stall=1 and issue=0 for one cycle. The following cycle gives fwd_sel=2 and issue=1.
- r5 written at stages 1 and 3, source r5 → fwd_sel=1 (youngest wins). The same entry with we=0 at stage 1 → fwd_sel=3.
- Flush asserted during a load-use stall → stall=0, issue=0. The next instruction reading r4 gets fwd_sel=2 from the still-shifting LD.
- reset=0 for one posedge with all stages holding r2 writers. Next cycle, source r2 → fwd_sel=0, stall=0.
- With HFU_ZERO_REG_EN: a writer of r0 followed by a reader of r0 → fwd_sel=0. Without it → fwd_sel=1. Repeat with DEPTH=4, NSRC=3: stage-4 match → fwd_sel=4.

Source files
------------

// File: rtl/hfu_pkg.sv
// Shared types and helpers for the hazard/forwarding unit.
package hfu_pkg;

  localparam int HFU_AW_MAX = 8;
  localparam int FWD_RF     = 0;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic                  load;
    logic [HFU_AW_MAX-1:0] addr;
  } hist_entry_t;

  function automatic int sel_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hfu_if.sv
// Decode-side bundle for hazard_forward_unit: instruction fields in, forwarding/stall out.
interface hfu_if #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int NSRC   = 2
) ();
  import hfu_pkg::*;

  localparam int SELW = sel_width(DEPTH);

  logic                   ins_valid;
  logic [NSRC*REG_AW-1:0] src_addr;
  logic [NSRC-1:0]        src_used;
  logic [REG_AW-1:0]      dst_addr;
  logic                   dst_we;
  logic                   is_load;
  logic                   flush;
  logic [NSRC*SELW-1:0]   fwd_sel;
  logic                   stall;
  logic                   issue;

  modport master (
    output ins_valid, src_addr, src_used, dst_addr, dst_we, is_load, flush,
    input  fwd_sel, stall, issue
  );

  modport slave (
    input  ins_valid, src_addr, src_used, dst_addr, dst_we, is_load, flush,
    output fwd_sel, stall, issue
  );

endinterface

// File: rtl/hfu_match.sv
// One source operand against the history: youngest-wins select plus stage-1 load hit.
// HFU_ZERO_REG_EN: source r0 never matches.
module hfu_match
  import hfu_pkg::*;
#(
  parameter  int REG_AW = 5,
  parameter  int DEPTH  = 3,
  localparam int SELW   = sel_width(DEPTH)
) (
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  input  hist_entry_t       hist [1:DEPTH],
  output logic [SELW-1:0]   sel,
  output logic              load_hit
);

  logic src_ok;
  logic unused_old_load;

`ifdef HFU_ZERO_REG_EN
  assign src_ok = used & (src != '0);
`else
  assign src_ok = used;
`endif

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    sel      = SELW'(FWD_RF);
    load_hit = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (src_ok && hist[k].valid && hist[k].we && (hist[k].addr == HFU_AW_MAX'(src))) begin
        sel = SELW'(k);
        if (k == 1) load_hit = hist[1].load;
      end
    end
  end

  always_comb begin
    unused_old_load = 1'b0;
    for (int k = 2; k <= DEPTH; k++) unused_old_load = unused_old_load ^ hist[k].load;
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Decode/execute data-hazard unit: destination history, forwarding selects, load-use stall.
// HFU_ZERO_REG_EN: r0 is hardwired zero (never written into history as a writer).
module hazard_forward_unit
  import hfu_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int NSRC   = 2
) (
  input logic  clk,
  input logic  reset,
  hfu_if.slave bus
);

  localparam int SELW = sel_width(DEPTH);

  if (REG_AW > HFU_AW_MAX) begin : g_aw_check
    $error("REG_AW exceeds HFU_AW_MAX");
  end

  hist_entry_t          hist [1:DEPTH];
  hist_entry_t          ins_entry;
  logic [NSRC-1:0]      load_hit;
  logic [NSRC*SELW-1:0] fwd_sel_c;
  logic                 stall_c;
  logic                 issue_c;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    hfu_match #(
      .REG_AW (REG_AW),
      .DEPTH  (DEPTH)
    ) u_match (
      .src      (bus.src_addr[i*REG_AW +: REG_AW]),
      .used     (bus.src_used[i]),
      .hist     (hist),
      .sel      (fwd_sel_c[i*SELW +: SELW]),
      .load_hit (load_hit[i])
    );
  end

  // Flush wins over stall: a squashed instruction never holds decode.
  assign stall_c     = bus.ins_valid & ~bus.flush & (|load_hit);
  assign issue_c     = bus.ins_valid & ~stall_c & ~bus.flush;
  assign bus.stall   = stall_c;
  assign bus.issue   = issue_c;
  assign bus.fwd_sel = fwd_sel_c;

  always_comb begin
    ins_entry.valid = issue_c;
`ifdef HFU_ZERO_REG_EN
    ins_entry.we    = bus.dst_we & (bus.dst_addr != '0);
`else
    ins_entry.we    = bus.dst_we;
`endif
    ins_entry.load  = bus.is_load;
    ins_entry.addr  = HFU_AW_MAX'(bus.dst_addr);
  end

  // History shift: addresses are qualified by valid, so only control bits see reset.
  always_ff @(posedge clk) begin
    hist[1].addr <= ins_entry.addr;
    for (int k = 2; k <= DEPTH; k++) hist[k].addr <= hist[k-1].addr;
    if (!reset) begin
      for (int k = 1; k <= DEPTH; k++) begin
        hist[k].valid <= 1'b0;
        hist[k].we    <= 1'b0;
        hist[k].load  <= 1'b0;
      end
    end else begin
      hist[1].valid <= ins_entry.valid;
      hist[1].we    <= ins_entry.we;
      hist[1].load  <= ins_entry.load;
      for (int k = 2; k <= DEPTH; k++) begin
        hist[k].valid <= hist[k-1].valid;
        hist[k].we    <= hist[k-1].we;
        hist[k].load  <= hist[k-1].load;
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed hazard scenarios plus random traffic vs. an issue-log model.
module tb_hazard_forward_unit;
  import hfu_pkg::*;

  localparam int REG_AW = 5;
  localparam int DEPTH  = 3;
  localparam int NSRC   = 2;
  localparam int SELW   = sel_width(DEPTH);

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hfu_if #(.REG_AW(REG_AW), .DEPTH(DEPTH), .NSRC(NSRC)) bus ();

  hazard_forward_unit #(.REG_AW(REG_AW), .DEPTH(DEPTH), .NSRC(NSRC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int cyc;
    bit we;
    bit ld;
    int addr;
  } rec_t;

  rec_t log_q[$];
  int   now      = 0;
  int   checks   = 0;
  int   failures = 0;

  int cur_src [NSRC];
  bit cur_used [NSRC];
  bit cur_iv, cur_we, cur_ld, cur_fl;
  int cur_dst;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Age of the youngest issued writer of src within the tracked window, else 0.
  function automatic int exp_sel(input int src, input bit used);
    if (!used) return 0;
`ifdef HFU_ZERO_REG_EN
    if (src == 0) return 0;
`endif
    for (int k = 1; k <= DEPTH; k++)
      foreach (log_q[j])
        if (log_q[j].cyc == now - k && log_q[j].we && log_q[j].addr == src) return k;
    return 0;
  endfunction

  function automatic bit exp_stall();
    if (!cur_iv || cur_fl) return 1'b0;
    for (int i = 0; i < NSRC; i++)
      if (exp_sel(cur_src[i], cur_used[i]) == 1)
        foreach (log_q[j])
          if (log_q[j].cyc == now - 1 && log_q[j].ld) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input bit iv, input int s0, input int s1, input bit [1:0] used,
                       input int dst, input bit we, input bit ld, input bit fl);
    cur_iv = iv; cur_src[0] = s0; cur_src[1] = s1;
    cur_used[0] = used[0]; cur_used[1] = used[1];
    cur_dst = dst; cur_we = we; cur_ld = ld; cur_fl = fl;
    bus.ins_valid = iv;
    bus.src_addr  = {REG_AW'(s1), REG_AW'(s0)};
    bus.src_used  = used;
    bus.dst_addr  = REG_AW'(dst);
    bus.dst_we    = we;
    bus.is_load   = ld;
    bus.flush     = fl;
  endtask

  task automatic tick();
    bit st, is;
    #2;
    st = exp_stall();
    is = cur_iv && !st && !cur_fl;
    check_val("stall", bus.stall, st);
    check_val("issue", bus.issue, is);
    if (is)
      for (int i = 0; i < NSRC; i++)
        check_val($sformatf("fwd_sel%0d", i), bus.fwd_sel[i*SELW +: SELW],
                  exp_sel(cur_src[i], cur_used[i]));
    @(posedge clk);
    if (!reset) log_q.delete();
    else if (is) begin
      rec_t r;
      r.cyc = now; r.ld = cur_ld; r.addr = cur_dst;
`ifdef HFU_ZERO_REG_EN
      r.we = cur_we && (cur_dst != 0);
`else
      r.we = cur_we;
`endif
      log_q.push_back(r);
    end
    now++;
    while (log_q.size() > 0 && log_q[0].cyc < now - DEPTH - 1) void'(log_q.pop_front());
    #1;
  endtask

  task automatic filler();
    drive(1, 10, 11, 2'b00, 9, 1, 0, 0);
    tick();
  endtask

  initial begin
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1, 1, 2, 2'b11, 1, 1, 1, 0);
    #2;
    check_val("rst_stall", bus.stall, 0);
    check_val("rst_fwd", bus.fwd_sel, 0);
    tick();
    reset = 1'b1;

    // Forwarding distance vs. number of unrelated instructions in between.
    for (int g = 0; g <= 3; g++) begin
      drive(1, 0, 0, 2'b00, 3, 1, 0, 0); tick();
      repeat (g) filler();
      drive(1, 3, 0, 2'b01, 8, 1, 0, 0);
      #2;
      check_val($sformatf("gap%0d", g), bus.fwd_sel[SELW-1:0], (g == 3) ? 0 : g + 1);
      tick();
    end

    // Load-use: one bubble, then forward from stage 2.
    drive(1, 0, 0, 2'b00, 4, 1, 1, 0); tick();
    drive(1, 4, 0, 2'b01, 6, 1, 0, 0);
    #2;
    check_val("lu_stall", bus.stall, 1);
    check_val("lu_issue", bus.issue, 0);
    tick();
    drive(1, 4, 0, 2'b01, 6, 1, 0, 0);
    #2;
    check_val("lu_after_stall", bus.stall, 0);
    check_val("lu_after_fwd", bus.fwd_sel[SELW-1:0], 2);
    tick();

    // Youngest writer wins; a non-writer is skipped.
    drive(1, 0, 0, 2'b00, 5, 1, 0, 0); tick();
    filler();
    drive(1, 0, 0, 2'b00, 5, 1, 0, 0); tick();
    drive(1, 0, 5, 2'b10, 7, 1, 0, 0);
    #2; check_val("youngest", bus.fwd_sel[SELW +: SELW], 1);
    tick();
    drive(1, 0, 0, 2'b00, 5, 1, 0, 0); tick();
    filler();
    drive(1, 0, 0, 2'b00, 5, 0, 0, 0); tick();
    drive(1, 0, 5, 2'b10, 7, 1, 0, 0);
    #2; check_val("we0_skip", bus.fwd_sel[SELW +: SELW], 3);
    tick();

    // Flush during a load-use stall.
    drive(1, 0, 0, 2'b00, 4, 1, 1, 0); tick();
    drive(1, 4, 0, 2'b01, 6, 1, 0, 1);
    #2;
    check_val("fl_stall", bus.stall, 0);
    check_val("fl_issue", bus.issue, 0);
    tick();
    drive(1, 4, 0, 2'b01, 6, 1, 0, 0);
    #2; check_val("fl_fwd", bus.fwd_sel[SELW-1:0], 2);
    tick();

    // Both sources hitting the same stage.
    drive(1, 0, 0, 2'b00, 6, 1, 0, 0); tick();
    drive(1, 6, 6, 2'b11, 9, 1, 0, 0);
    #2; check_val("both_src", bus.fwd_sel, {SELW'(1), SELW'(1)});
    tick();

    // Reset discards full history of r2 writers.
    repeat (3) begin drive(1, 0, 0, 2'b00, 2, 1, 1, 0); tick(); end
    reset = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0); tick();
    reset = 1'b1;
    drive(1, 2, 2, 2'b11, 9, 1, 0, 0);
    #2;
    check_val("post_rst_fwd", bus.fwd_sel, 0);
    check_val("post_rst_stall", bus.stall, 0);
    tick();

    // r0 handling.
    drive(1, 0, 0, 2'b00, 0, 1, 0, 0); tick();
    drive(1, 0, 0, 2'b01, 9, 1, 0, 0);
    #2;
`ifdef HFU_ZERO_REG_EN
    check_val("r0_fwd", bus.fwd_sel[SELW-1:0], 0);
`else
    check_val("r0_fwd", bus.fwd_sel[SELW-1:0], 1);
`endif
    tick();

    // Random traffic over a small register set to force frequent hazards.
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(63) != 0);
      drive($urandom_range(7) != 0, $urandom_range(3), $urandom_range(3),
            2'($urandom_range(3)), $urandom_range(3), $urandom_range(1) == 1,
            $urandom_range(2) == 0, $urandom_range(7) == 0);
      tick();
    end
    reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
